// File: rtl/fifo_pkg.sv
// Shared constants and read-port FSM encoding for the 8-deep stack FIFO.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH   = 8;
    localparam int unsigned STACK_HEIGHT = 8;
    localparam int unsigned PTR_WIDTH    = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StBurst  = 2'd2,
        StFlush  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register FIFO; head is always the oldest entry.
module skid_buf2 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]            occ_q, occ_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        if (pop && (occ_q != 2'd0)) begin
            e0_d  = e1_q;
            occ_d = occ_q - 2'd1;
        end
        // Tail slot depends on occupancy after any same-cycle pop.
        if (push) begin
            if (occ_d == 2'd0) begin
                e0_d = push_data;
            end else begin
                e1_d = push_data;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = e0_q;

endmodule

// File: rtl/fifo_read_port.sv
// Read-side master for the stack FIFO: credit-limited pop strobes feeding a
// 2-entry skid buffer presented as a valid/ready stream, with optional bursts.
module fifo_read_port #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stack_empty,
    output logic                  read_from_stack,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  burst_mode,
    input  logic                  burst_go,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  burst_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_total
);

    import fifo_pkg::*;

    rd_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic [CNT_WIDTH-1:0] rd_total_q;
    logic                 pend_q;
    logic                 from_burst_q, from_burst_d;
    logic [1:0]           occ;
    logic                 pop;
    logic                 credit_ok;
    logic                 issue_ok;

    skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (pend_q),
        .push_data(fifo_data),
        .pop      (pop),
        .occ      (occ),
        .head     (m_data)
    );

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_ready;

    always_comb begin
        // occ + pend - pop < 2, rearranged to stay unsigned.
        credit_ok = ({1'b0, occ} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop});
        issue_ok  = (state_q == StStream) ||
                    ((state_q == StBurst) && (bcnt_q != '0));
        read_from_stack = issue_ok && !stack_empty && credit_ok;
    end

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        from_burst_d = from_burst_q;
        unique case (state_q)
            StIdle: begin
                from_burst_d = 1'b0;
                if (!burst_mode) begin
                    state_d = StStream;
                end else if (burst_go) begin
                    state_d      = StBurst;
                    bcnt_d       = CNT_WIDTH'(BURST_LEN);
                    from_burst_d = 1'b1;
                end
            end
            StStream: begin
                if (burst_mode) begin
                    state_d = StFlush;
                end
            end
            StBurst: begin
                if (read_from_stack) begin
                    bcnt_d = bcnt_q - CNT_WIDTH'(1);
                end
                if (bcnt_d == '0) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if ((occ == 2'd0) && !pend_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Final burst word: last buffered entry leaves with nothing in flight.
    assign burst_done = (state_q == StFlush) && from_burst_q && pop &&
                        (occ == 2'd1) && !pend_q;
    assign busy       = (state_q != StIdle) || (occ != 2'd0) || pend_q;
    assign rd_total   = rd_total_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            bcnt_q       <= '0;
            pend_q       <= 1'b0;
            from_burst_q <= 1'b0;
            rd_total_q   <= '0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            pend_q       <= read_from_stack;
            from_burst_q <= from_burst_d;
            if (pop) begin
                rd_total_q <= rd_total_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule
